// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: frame constants, state encoding and parity helper,
// common to the transmit and receive sides.
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam int   IDX_W      = $clog2(DATA_BITS);
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_t;

   // Even parity is the XOR of all data bits; odd parity is its inverse.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/tx_uart_if.sv
`timescale 1ns/1ps
// Byte handshake between a requester (master) and the UART transmitter (slave).
interface tx_uart_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data_in;
   logic                 valid;
   logic                 ready;

   modport master (output data_in, output valid, input ready);
   modport slave  (input data_in, input valid, output ready);

endinterface

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the
// last cycle of each bit with bit_tick. Restarting clears the count so the
// first bit of a frame is a full period.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_restart,
   output logic o_bit_tick
);

   localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Bit-period counter: held at zero when idle, reloads at every bit boundary.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create ordering races.
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_restart || !i_en) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_bit_tick = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/tx_uart.sv
`timescale 1ns/1ps
// UART transmitter: accepts a byte on a valid/ready handshake and sends
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module tx_uart
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   tx_uart_if.slave   bus,
   output logic       Tx,
   output logic       busy,
   output logic       done
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);
   localparam logic             ODD_SEL   = (PARITY_ODD != 0);
   localparam bit               PAR_ON    = (PARITY_EN != 0);

   uart_state_t          r_state, w_state_next;
   logic                 r_tx, w_tx_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
   logic                 r_stop_idx, w_stop_idx_next;
   logic                 r_parity, w_parity_next;
   logic                 r_done, w_done_next;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_bit_tick;

   assign w_ready   = (r_state == S_IDLE);
   assign w_accept  = bus.valid && w_ready;
   assign bus.ready = w_ready;
   assign busy      = ~w_ready;
   assign Tx        = r_tx;
   assign done      = r_done;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .rst        (rst),
      .i_en       (~w_ready),
      .i_restart  (w_accept),
      .o_bit_tick (w_bit_tick)
   );

   // Next-state and next-output decode; Tx is computed one edge ahead so it
   // leaves a register with no combinational glitches.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      w_state_next    = r_state;
      w_tx_next       = r_tx;
      w_shift_next    = r_shift;
      w_bit_idx_next  = r_bit_idx;
      w_stop_idx_next = r_stop_idx;
      w_parity_next   = r_parity;
      w_done_next     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_next = IDLE_LEVEL;
            if (w_accept) begin
               w_state_next    = S_START;
               w_tx_next       = 1'b0;
               w_shift_next    = bus.data_in;
               w_parity_next   = calc_parity(bus.data_in, ODD_SEL);
               w_bit_idx_next  = '0;
               w_stop_idx_next = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_tick) begin
               w_state_next = S_DATA;
               w_tx_next    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_tick) begin
               if (r_bit_idx == LAST_IDX) begin
                  w_bit_idx_next = '0;
                  if (PAR_ON) begin
                     w_state_next = S_PARITY;
                     w_tx_next    = r_parity;
                  end else begin
                     w_state_next = S_STOP;
                     w_tx_next    = IDLE_LEVEL;
                  end
               end else begin
                  w_bit_idx_next = r_bit_idx + IDX_W'(1);
                  w_shift_next   = r_shift >> 1;
                  w_tx_next      = r_shift[1];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_tick) begin
               w_state_next = S_STOP;
               w_tx_next    = IDLE_LEVEL;
            end
         end
         S_STOP: begin
            if (w_bit_tick) begin
               if (r_stop_idx == LAST_STOP) begin
                  w_state_next    = S_IDLE;
                  w_stop_idx_next = 1'b0;
                  w_done_next     = 1'b1;
               end else begin
                  w_stop_idx_next = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_tx_next    = IDLE_LEVEL;
         end
      endcase
   end

   // State, shifter and output registers; reset aborts any frame at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tx       <= IDLE_LEVEL;
         // NOTE: the shifter is a handful of flops, not a memory, so it is
         // cleared with everything else and the datapath restarts known.
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_parity   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_tx       <= w_tx_next;
         r_shift    <= w_shift_next;
         r_bit_idx  <= w_bit_idx_next;
         r_stop_idx <= w_stop_idx_next;
         r_parity   <= w_parity_next;
         r_done     <= w_done_next;
      end
   end

endmodule

// File: tb/tb_tx_uart.sv
`timescale 1ns/1ps
// Bench for tx_uart: four instances at CLKS_PER_BIT=4 (default framing, even
// parity, odd parity, even parity with two stop bits). Stimulus pushes the
// hand-derived line sequence of each frame into a per-instance queue; a
// monitor per instance walks the Tx line cycle by cycle and compares.
module tb_tx_uart;

   localparam int CPB = 4;
   localparam int NDUT = 4;

   typedef struct {
      logic [11:0] bits;        // line levels in time order, first bit leftmost
      int          nbits;
      int          accept_cyc;  // cycle valid was driven, -1 when not checked
      int          delta;       // start-to-start spacing, 0 when not checked
      int          abort_after; // full bits before reset, -1 for whole frame
   } exp_t;

   logic                clk;
   logic [NDUT-1:0]     rst_v;
   logic [NDUT-1:0]     valid_v;
   logic [7:0]          data_v [NDUT];
   logic [NDUT-1:0]     rdy;
   logic [NDUT-1:0]     tx_w;
   logic [NDUT-1:0]     busy_w;
   logic [NDUT-1:0]     done_w;

   exp_t exp_q [NDUT][$];
   int   frames_seen [NDUT];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   tx_uart_if bus0 ();
   tx_uart_if bus1 ();
   tx_uart_if bus2 ();
   tx_uart_if bus3 ();

   assign bus0.valid = valid_v[0];  assign bus0.data_in = data_v[0];  assign rdy[0] = bus0.ready;
   assign bus1.valid = valid_v[1];  assign bus1.data_in = data_v[1];  assign rdy[1] = bus1.ready;
   assign bus2.valid = valid_v[2];  assign bus2.data_in = data_v[2];  assign rdy[2] = bus2.ready;
   assign bus3.valid = valid_v[3];  assign bus3.data_in = data_v[3];  assign rdy[3] = bus3.ready;

   tx_uart #(.CLKS_PER_BIT(CPB)) dut0 (
      .clk(clk), .rst(rst_v[0]), .bus(bus0.slave), .Tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   tx_uart #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rst(rst_v[1]), .bus(bus1.slave), .Tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   tx_uart #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .rst(rst_v[2]), .bus(bus2.slave), .Tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
   tx_uart #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst(rst_v[3]), .bus(bus3.slave), .Tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Caller is at a negedge. Drives one byte and queues its expected frame.
   task automatic send(input int id, input logic [7:0] d, input logic [11:0] bits,
                       input int nb, input int abort_after, input bit hold);
      int   g = 0;
      exp_t it;
      while (!rdy[id] && g < 200) begin
         @(negedge clk);
         g++;
      end
      check($sformatf("dut%0d ready before send", id), rdy[id], 1);
      data_v[id]  = d;
      valid_v[id] = 1'b1;
      it = '{bits, nb, cyc, 0, abort_after};
      exp_q[id].push_back(it);
      @(negedge clk);
      if (!hold) valid_v[id] = 1'b0;
   endtask

   task automatic wait_idle(input int id);
      int g = 0;
      while ((exp_q[id].size() != 0 || !rdy[id]) && g < 300) begin
         @(negedge clk);
         g++;
      end
      check($sformatf("dut%0d drained", id), (exp_q[id].size() == 0) && rdy[id], 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic monitor(input int id);
      exp_t it;
      int   last_start = -1;
      bit   post = 0;
      int   good, done_hits, nfull;
      bit   aborted;
      forever begin
         @(negedge clk);
         if (post) begin
            check($sformatf("dut%0d done width", id), done_w[id], 0);
            post = 0;
         end
         if (rst_v[id] && tx_w[id] == 1'b0) begin
            frames_seen[id]++;
            check($sformatf("dut%0d frame expected", id), exp_q[id].size() != 0, 1);
            if (exp_q[id].size() == 0) begin
               repeat (60) @(negedge clk);
               continue;
            end
            it = exp_q[id].pop_front();
            check($sformatf("dut%0d busy in frame", id), {rdy[id], busy_w[id]}, 2'b01);
            if (it.accept_cyc >= 0)
               check($sformatf("dut%0d start latency", id), cyc - it.accept_cyc, 1);
            if (it.delta > 0)
               check($sformatf("dut%0d start spacing", id), cyc - last_start, it.delta);
            last_start = cyc;
            aborted = 0;
            nfull = 0;
            done_hits = 0;
            for (int b = 0; b < it.nbits; b++) begin
               good = 0;
               for (int c = 0; c < CPB; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (!rst_v[id]) begin
                     aborted = 1;
                     break;
                  end
                  if (tx_w[id] === it.bits[it.nbits-1-b]) good++;
                  if (done_w[id] !== 1'b0) done_hits++;
               end
               if (aborted) break;
               check($sformatf("dut%0d frame%0d bit%0d level", id, frames_seen[id], b), good, CPB);
               nfull++;
            end
            if (aborted || it.abort_after >= 0)
               check($sformatf("dut%0d abort point", id), nfull, it.abort_after);
            if (!aborted) begin
               check($sformatf("dut%0d done in frame", id), done_hits, 0);
               @(negedge clk);
               check($sformatf("dut%0d done pulse", id), {done_w[id], tx_w[id], rdy[id]}, 3'b111);
               post = 1;
            end
         end
      end
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
         monitor(2);
         monitor(3);
      join_none
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst_v   = '0;
      valid_v = '0;
      for (int i = 0; i < NDUT; i++) begin
         data_v[i]      = 8'h00;
         frames_seen[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("dut%0d reset Tx", i), tx_w[i], 1);
         check($sformatf("dut%0d reset ready", i), rdy[i], 1);
         check($sformatf("dut%0d reset busy", i), busy_w[i], 0);
         check($sformatf("dut%0d reset done", i), done_w[i], 0);
      end

      // Release and send on the very first edge: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
      rst_v = '1;
      send(0, 8'hA5, 12'b0101001011, 10, -1, 0);
      wait_idle(0);

      // 0xC3 with a stray valid/data change mid-frame, which must be ignored
      send(0, 8'hC3, 12'b0110000111, 10, -1, 0);
      repeat (8) @(negedge clk);
      check("dut0 ready low mid-frame", rdy[0], 0);
      data_v[0]  = 8'h3C;
      valid_v[0] = 1'b1;
      @(negedge clk);
      valid_v[0] = 1'b0;
      wait_idle(0);
      repeat (60) @(negedge clk);

      // 0x0F aborted by reset inside data bit 3 (start + bits 0..2 complete)
      send(0, 8'h0F, 12'b0111100001, 10, 4, 0);
      repeat (17) @(negedge clk);
      #1 rst_v[0] = 1'b0;
      #1;
      check("dut0 abort Tx", tx_w[0], 1);
      check("dut0 abort ready", rdy[0], 1);
      check("dut0 abort busy", busy_w[0], 0);
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dut0 no done after abort", done_w[0], 0);
      end
      send(0, 8'h81, 12'b0100000011, 10, -1, 0);
      wait_idle(0);

      // Even parity 0xA5: parity 0; odd parity 0xA5: parity 1 (44-cycle frames)
      send(1, 8'hA5, 12'b01010010101, 11, -1, 0);
      wait_idle(1);
      send(2, 8'hA5, 12'b01010010111, 11, -1, 0);
      wait_idle(2);

      // Two stop bits with parity, valid held: 0x00 then 0xFF, starts 49 apart
      send(3, 8'h00, 12'b000000000011, 12, -1, 1);
      exp_q[3].push_back('{12'b011111111011, 12, -1, 49, -1});
      data_v[3] = 8'hFF;
      g = 0;
      while (!rdy[3] && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("dut3 second accept window", rdy[3], 1);
      @(negedge clk);
      valid_v[3] = 1'b0;
      wait_idle(3);

      repeat (60) @(negedge clk);
      check("dut0 frame count", frames_seen[0], 4);
      check("dut1 frame count", frames_seen[1], 1);
      check("dut2 frame count", frames_seen[2], 1);
      check("dut3 frame count", frames_seen[3], 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-007 data_in  input  8  byte to transmit; sampled only on acceptance.
REQ-008 valid  input  1  requester has a byte on data_in.
REQ-009 ready  output  1  block can accept a byte this cycle.
REQ-010 Tx  output  1  serial line; idle high.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; data_in SHALL be latched into an internal shift register at that edge.
REQ-014 ready SHALL be 1 only in state IDLE; busy SHALL equal the inverse of ready.
REQ-015 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on acceptance; START->DATA; DATA->PARITY after bit 7 when PARITY_EN=1, else DATA->STOP; PARITY->STOP; STOP->IDLE after the last stop bit.
REQ-016 Tx SHALL be driven from a register; Tx=1 in IDLE and STOP, 0 in START, the current data bit in DATA, and the parity bit in PARITY.
REQ-017 Data bits SHALL be sent LSB first (bit 0 first, bit 7 last).
REQ-018 The parity bit SHALL be the XOR of the 8 latched bits, inverted when PARITY_ODD=1.
REQ-019 Every START, DATA, PARITY and STOP bit SHALL hold Tx stable for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at each bit boundary.
REQ-020 Latency: the Tx falling edge of the start bit SHALL appear in the first cycle after the acceptance edge.
REQ-021 Frame length, from the first start-bit cycle to the last stop-bit cycle, SHALL be (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 done SHALL pulse high for exactly one cycle, in the first IDLE cycle after STOP.
REQ-023 Back-to-back: valid held high SHALL be accepted in that first IDLE cycle, so consecutive frames are separated by exactly one extra idle-high cycle.
REQ-024 valid asserted while busy=1 SHALL be ignored, and the in-flight frame SHALL be unaffected; data_in changes during a frame SHALL have no effect.
REQ-025 The bit-period and bit-index counters SHALL be sized to hold their maximum values with no wrap inside a frame; the bit index SHALL wrap to 0 on the DATA exit.

Reset
REQ-026 While rst=0, outputs SHALL be Tx=1, ready=1, busy=0, done=0; state=IDLE; all counters and the shift register =0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), drive Tx=1 and produce no done pulse.
REQ-028 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 State encodings and the frame constants (DATA_BITS=8, IDLE_LEVEL=1) SHALL reside in a shared package uart_pkg, also used by the UART receive side.
REQ-030 Bit timing SHALL be a sub-module uart_baud_gen (counter plus bit_tick output, restarted on acceptance); the FSM and shifter SHALL reside in tx_uart.

Verification
REQ-031 CLKS_PER_BIT=4, defaults otherwise, send 0xA5 -> Tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), then done pulses once.
REQ-032 PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit=0; repeat with PARITY_ODD=1 -> parity bit=1; frame=44 cycles.
REQ-033 STOP_BITS=2, valid held high with 0x00 then 0xFF -> second start bit begins exactly 12*4+1 cycles after the first start bit; no accept while busy.
REQ-034 Pulse valid with 0x3C mid-frame -> ignored; the current frame is bit-exact and no extra frame is sent.
REQ-035 Assert rst during DATA bit 3 -> Tx=1, ready=1 in the same cycle, no done pulse; the next byte 0x81 transmits correctly.
